pwm_duty_decoder: RTL and testbench

Receive-side counterpart of the microwave motor PWM drive. Samples the motor PWM line and the 2-bit motor control bus, then measures the PWM period and high time. Classifies the result as OFF, DEFROST, COOK or OTHER and flags malformed periods or a stuck line. Sits between the motor drive pins and the status/fault logic so the controller FSM can confirm the motor is doing what was commanded.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_sync_edge.sv | 29 ++
 rtl/pwm_duty_decoder.sv | 155 +++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM mode encodings, motor control codes and drive-side defaults
package pwm_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_DEFROST = 2'd1;
  localparam logic [1:0] MODE_COOK    = 2'd2;
  localparam logic [1:0] MODE_OTHER   = 2'd3;

  localparam logic [1:0] MOTOR_RUN  = 2'b10;
  localparam logic [1:0] MOTOR_STOP = 2'b11;

  // Defaults shared with the drive side so both ends agree on the waveform
  localparam int PWM_PERIOD       = 10;
  localparam int PWM_COOK_DUTY    = 7;
  localparam int PWM_DEFROST_DUTY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_STALE
  } pwm_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - 2-flop synchronizer with delay flop and rise/fall pulses
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign rise = sync & ~dly;
  assign fall = ~sync & dly;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures motor PWM period/high time and classifies the mode
// Optional PWM_DIR_CHECK_EN adds dir_err, cross-checking mode against moter_control.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int PERIOD       = PWM_PERIOD,
  parameter int TIMEOUT      = 32,
  parameter int COOK_DUTY    = PWM_COOK_DUTY,
  parameter int DEFROST_DUTY = PWM_DEFROST_DUTY,
  localparam int CW          = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  input  logic [1:0]    moter_control,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          meas_valid,
  output logic [1:0]    mode,
  output logic          period_err,
  output logic          stuck_high
`ifdef PWM_DIR_CHECK_EN
  ,
  output logic          dir_err
`endif
);

  localparam logic [CW-1:0] CW_PERIOD  = CW'(PERIOD);
  localparam logic [CW-1:0] CW_TIMEOUT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CW_COOK    = CW'(COOK_DUTY);
  localparam logic [CW-1:0] CW_DEFROST = CW'(DEFROST_DUTY);

  logic          pwm_s;
  logic          pwm_rise;
  logic          pwm_fall_unused;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] cap_duty;
  logic [1:0]    cap_mode;
  pwm_state_t    state;

  pwm_sync_edge u_pwm_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .sync (pwm_s),
    .rise (pwm_rise),
    .fall (pwm_fall_unused)
  );

  // Both counters restart at 1 on a rise so the rise cycle itself is counted
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (pwm_rise) begin
      period_cnt <= CW'(1);
      high_cnt   <= CW'(1);
    end else begin
      if (period_cnt != CW_TIMEOUT) period_cnt <= period_cnt + 1'b1;
      if (pwm_s && (high_cnt != CW_TIMEOUT)) high_cnt <= high_cnt + 1'b1;
    end
  end

  always_comb begin
    cap_duty = high_cnt;
    if (state == ST_STALE) cap_duty = pwm_s ? CW_PERIOD : '0;
  end

  always_comb begin
    cap_mode = MODE_OTHER;
    if (cap_duty == '0)              cap_mode = MODE_OFF;
    else if (cap_duty == CW_DEFROST) cap_mode = MODE_DEFROST;
    else if (cap_duty == CW_COOK)    cap_mode = MODE_COOK;
  end

`ifdef PWM_DIR_CHECK_EN
  logic [1:0] ctrl_s;
  logic [1:0] ctrl_rise_unused;
  logic [1:0] ctrl_fall_unused;
  logic       cap_dir_err;

  for (genvar i = 0; i < 2; i++) begin : g_ctrl_sync
    pwm_sync_edge u_ctrl_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (moter_control[i]),
      .sync (ctrl_s[i]),
      .rise (ctrl_rise_unused[i]),
      .fall (ctrl_fall_unused[i])
    );
  end

  always_comb begin
    cap_dir_err = 1'b1;
    if (ctrl_s == MOTOR_STOP)     cap_dir_err = (cap_mode != MODE_OFF);
    else if (ctrl_s == MOTOR_RUN) cap_dir_err = (cap_mode == MODE_OFF);
  end
`else
  logic ctrl_unused;
  assign ctrl_unused = ^moter_control;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      duty       <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      mode       <= MODE_OFF;
      period_err <= 1'b0;
      stuck_high <= 1'b0;
`ifdef PWM_DIR_CHECK_EN
      dir_err    <= 1'b0;
`endif
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pwm_rise) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          // A rise coinciding with the timeout still counts as a real period
          if (pwm_rise) begin
            duty       <= cap_duty;
            period     <= period_cnt;
            meas_valid <= 1'b1;
            mode       <= cap_mode;
            period_err <= (period_cnt != CW_PERIOD);
            stuck_high <= 1'b0;
`ifdef PWM_DIR_CHECK_EN
            dir_err    <= cap_dir_err;
`endif
          end else if (period_cnt == CW_TIMEOUT) begin
            state <= ST_STALE;
          end
        end
        ST_STALE: begin
          duty       <= cap_duty;
          period     <= '0;
          meas_valid <= 1'b1;
          mode       <= cap_mode;
          period_err <= 1'b0;
          stuck_high <= pwm_s;
`ifdef PWM_DIR_CHECK_EN
          dir_err    <= cap_dir_err;
`endif
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - table-driven scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [1:0] moter_control = 2'b10;
  logic [5:0] duty;
  logic [5:0] period;
  logic       meas_valid;
  logic [1:0] mode;
  logic       period_err;
  logic       stuck_high;
`ifdef PWM_DIR_CHECK_EN
  logic       dir_err;
`endif

  pwm_duty_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .moter_control (moter_control),
    .duty          (duty),
    .period        (period),
    .meas_valid    (meas_valid),
    .mode          (mode),
    .period_err    (period_err),
    .stuck_high    (stuck_high)
`ifdef PWM_DIR_CHECK_EN
    ,
    .dir_err       (dir_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         high;
    int         per;
    int         n;
    logic [1:0] ctrl;
    int         exp_mode;
    int         exp_err;
  } seg_t;

  typedef struct {
    int duty;
    int period;
    int mode;
    int err;
    int stuck;
    int dir;
  } exp_t;

  seg_t segs[6];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   armed = 0;
  seg_t prev;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dir_model(input logic [1:0] ctrl, input int m);
    if (ctrl == 2'b11) return (m != 0) ? 1 : 0;
    if (ctrl == 2'b10) return (m == 0) ? 1 : 0;
    return 1;
  endfunction

  task automatic step(input logic v);
    pwm_in = v;
    @(posedge clk);
    #1;
  endtask

  // A rise closes the previous period, so its expectation is queued here
  task automatic note_rise();
    exp_t e;
    if (armed != 0) begin
      e.duty = prev.high; e.period = prev.per; e.mode = prev.exp_mode;
      e.err = prev.exp_err; e.stuck = 0; e.dir = dir_model(moter_control, prev.exp_mode);
      sb.push_back(e);
    end
  endtask

  task automatic run_period(input seg_t s);
    note_rise();
    armed = 1;
    prev = s;
    for (int c = 0; c < s.per; c++) step(c < s.high);
  endtask

  task automatic push_stale(input int d, input int m, input int st);
    exp_t e;
    e.duty = d; e.period = 0; e.mode = m; e.err = 0; e.stuck = st;
    e.dir = dir_model(moter_control, m);
    sb.push_back(e);
    armed = 0;
  endtask

  task automatic mon_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && meas_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_meas_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("duty", int'(duty), e.duty);
          chk("period", int'(period), e.period);
          chk("mode", int'(mode), e.mode);
          chk("period_err", int'(period_err), e.err);
          chk("stuck_high", int'(stuck_high), e.stuck);
`ifdef PWM_DIR_CHECK_EN
          chk("dir_err", int'(dir_err), e.dir);
`endif
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_period_err"}, int'(period_err), 0);
    chk({tag, "_stuck_high"}, int'(stuck_high), 0);
`ifdef PWM_DIR_CHECK_EN
    chk({tag, "_dir_err"}, int'(dir_err), 0);
`endif
  endtask

  initial begin
    seg_t cook;
    segs[0] = '{high: 7, per: 10, n: 4, ctrl: 2'b10, exp_mode: 2, exp_err: 0};
    segs[1] = '{high: 2, per: 10, n: 3, ctrl: 2'b10, exp_mode: 1, exp_err: 0};
    segs[2] = '{high: 7, per: 10, n: 2, ctrl: 2'b11, exp_mode: 2, exp_err: 0};
    segs[3] = '{high: 5, per: 12, n: 3, ctrl: 2'b10, exp_mode: 3, exp_err: 1};
    segs[4] = '{high: 5, per: 32, n: 2, ctrl: 2'b10, exp_mode: 3, exp_err: 1};
    segs[5] = '{high: 7, per: 10, n: 3, ctrl: 2'b10, exp_mode: 2, exp_err: 0};
    cook = segs[0];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    fork
      mon_loop();
    join_none

    for (int i = 0; i < 6; i++) begin
      moter_control = segs[i].ctrl;
      for (int k = 0; k < segs[i].n; k++) run_period(segs[i]);
    end

    // Line goes quiet after a COOK period: one OFF result, then silence
    push_stale(0, 0, 0);
    repeat (40) step(1'b0);

    // Stuck high from idle: first rise is not a capture, then one stale result
    push_stale(10, 3, 1);
    repeat (40) step(1'b1);
    repeat (3) step(1'b0);
    for (int k = 0; k < 3; k++) run_period(cook);

    // Reset in the low phase of a period discards the partial measurement
    note_rise();
    for (int c = 0; c < 8; c++) step(c < 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("midreset");
    armed = 0;
    step(1'b0);
    step(1'b0);
    for (int k = 0; k < 3; k++) run_period(cook);

    push_stale(0, 0, 0);
    repeat (40) step(1'b0);
    repeat (5) step(1'b0);
    chk("pending_results", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
